// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared types and defaults for the next-PC generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_gen_pkg;

  localparam int PC_W_DEF        = 32;
  localparam int FETCH_WIDTH_DEF = 2;

  typedef logic [PC_W_DEF-1:0] addr_t;

  localparam addr_t RESET_PC_DEF = 32'hbfc0_0000;

  // IDLE: normal fetch; WAIT_DS: redirect target parked until delay slot leaves
  typedef enum logic {
    IDLE    = 1'b0,
    WAIT_DS = 1'b1
  } pcgen_state_e;

  // Width of the word-offset field inside a bundle (at least 1 bit so it can be declared)
  function automatic int off_width(input int fw);
    return (fw > 1) ? $clog2(fw) : 1;
  endfunction

endpackage

// File: rtl/pc_gen_redirect_sel.sv
// pc_gen_redirect_sel: priority mux of control-flow redirects (branch > jr > jump).
// Latency: purely combinational.
// Backpressure: none; the caller decides when the selected target is applied.
module pc_gen_redirect_sel #(
  parameter int PC_W = 32
) (
  input  logic            i_branch_taken,
  input  logic [PC_W-1:0] i_pcbranch,
  input  logic            i_jr,
  input  logic [PC_W-1:0] i_pcjr,
  input  logic            i_jump,
  input  logic [PC_W-1:0] i_pcjump,
  output logic            o_redir,
  output logic [PC_W-1:0] o_target
);

  assign o_redir = i_branch_taken | i_jr | i_jump;

  // Highest-priority requester supplies the target
  always_comb begin
    o_target = i_pcbranch;
    if (i_branch_taken) begin
      o_target = i_pcbranch;
    end else if (i_jr) begin
      o_target = i_pcjr;
    end else if (i_jump) begin
      o_target = i_pcjump;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch PC register, bundle slot mask and redirect/delay-slot sequencing.
// Latency: redirect or exception reaches pc_o one cycle later; flush_o is same-cycle.
// Backpressure: pc_o/slot_mask_o hold while pc_valid_o & !pc_ready_i unless redirected.
// Optional: define PC_GEN_STAT_EN to add saturating redirect/exception counters.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              FETCH_WIDTH = FETCH_WIDTH_DEF,
  parameter int              PC_W        = PC_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(RESET_PC_DEF)
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   pc_valid_o,
  input  logic                   pc_ready_i,
  output logic [PC_W-1:0]        pc_o,
  output logic [FETCH_WIDTH-1:0] slot_mask_o,
  input  logic                   exc_valid_i,
  input  logic [PC_W-1:0]        exc_pc_i,
  input  logic                   branch_taken_i,
  input  logic [PC_W-1:0]        pcbranch_i,
  input  logic                   jr_i,
  input  logic [PC_W-1:0]        pcjr_i,
  input  logic                   jump_i,
  input  logic [PC_W-1:0]        pcjump_i,
  input  logic                   ds_fetched_i,
  output logic                   flush_o,
  output logic                   wait_ds_o
`ifdef PC_GEN_STAT_EN
  ,
  output logic [31:0]            stat_redirect_o,
  output logic [31:0]            stat_exc_o
`endif
);

  localparam int              OFF_W      = off_width(FETCH_WIDTH);
  localparam logic [PC_W-1:0] BUNDLE_B   = PC_W'(4 * FETCH_WIDTH);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~(PC_W'(4 * FETCH_WIDTH - 1));

  pcgen_state_e    r_state;
  pcgen_state_e    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_tgt;
  logic            r_vld;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_tgt_nxt;
  logic [PC_W-1:0] w_seq_pc;
  logic [PC_W-1:0] w_redir_tgt;
  logic            w_redir;
  logic            w_fire;
  logic [OFF_W-1:0] w_off;

  pc_gen_redirect_sel #(
    .PC_W (PC_W)
  ) u_redirect_sel (
    .i_branch_taken (branch_taken_i),
    .i_pcbranch     (pcbranch_i),
    .i_jr           (jr_i),
    .i_pcjr         (pcjr_i),
    .i_jump         (jump_i),
    .i_pcjump       (pcjump_i),
    .o_redir        (w_redir),
    .o_target       (w_redir_tgt)
  );

  assign w_fire   = pc_valid_o & pc_ready_i;
  assign w_seq_pc = (r_pc & ALIGN_MASK) + BUNDLE_B;

  // Word position of pc within its bundle; a single-slot bundle has no offset
  generate
    if (FETCH_WIDTH > 1) begin : g_off
      assign w_off = r_pc[2 +: OFF_W];
    end else begin : g_no_off
      assign w_off = '0;
    end
  endgenerate

  // Next state: exception first, then redirect (direct or parked), then sequential fetch
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_tgt_nxt   = r_tgt;
    if (exc_valid_i) begin
      w_pc_nxt    = exc_pc_i;
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_redir && ds_fetched_i) begin
            w_pc_nxt = w_redir_tgt;
          end else if (w_redir) begin
            w_tgt_nxt   = w_redir_tgt;
            w_state_nxt = WAIT_DS;
          end else if (w_fire) begin
            w_pc_nxt = w_seq_pc;
          end
        end
        WAIT_DS: begin
          // Delay slot accepted by fetch: now jump to the parked target
          if (w_fire) begin
            w_pc_nxt    = r_tgt;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Outputs: bundle request, slot mask (delay slot alone while waiting) and flush
  always_comb begin
    pc_valid_o  = r_vld & ~reset;
    pc_o        = r_pc;
    wait_ds_o   = (r_state == WAIT_DS);
    flush_o     = 1'b0;
    slot_mask_o = '0;
    if (!reset) begin
      flush_o = exc_valid_i | ((r_state == IDLE) & w_redir & ds_fetched_i);
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      if (r_state == WAIT_DS) begin
        slot_mask_o[i] = (i == int'(w_off));
      end else begin
        slot_mask_o[i] = (i >= int'(w_off));
      end
    end
  end

  // State register; valid rises one cycle after reset is released
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_tgt   <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_tgt   <= w_tgt_nxt;
      r_vld   <= 1'b1;
    end
  end

`ifdef PC_GEN_STAT_EN
  logic        w_redir_done;
  logic [31:0] r_stat_redirect;
  logic [31:0] r_stat_exc;

  assign w_redir_done = ~exc_valid_i &
                        (((r_state == IDLE) & w_redir & ds_fetched_i) |
                         ((r_state == WAIT_DS) & w_fire));

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_redirect <= '0;
      r_stat_exc      <= '0;
    end else begin
      if (w_redir_done && (r_stat_redirect != '1)) begin
        r_stat_redirect <= r_stat_redirect + 32'd1;
      end
      if (exc_valid_i && (r_stat_exc != '1)) begin
        r_stat_exc <= r_stat_exc + 32'd1;
      end
    end
  end

  assign stat_redirect_o = r_stat_redirect;
  assign stat_exc_o      = r_stat_exc;
`endif

  // A second redirect while a delay slot is pending is an upstream protocol error
  assert property (@(posedge clk) disable iff (reset) !((r_state == WAIT_DS) && w_redir))
    else $error("pc_gen: redirect received while waiting for delay slot");

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scenarios plus randomized run against a behavioural model.
// Latency: checks pc_o one cycle after redirects, flush_o in the same cycle.
// Backpressure: pc_ready_i toggled by scenario and at random.
module tb_pc_gen;

  localparam int          FW  = 2;
  localparam logic [31:0] RPC = 32'hbfc0_0000;
  localparam logic [31:0] BB  = 32'(4 * FW);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pc_valid_o;
  logic          pc_ready_i = 1'b0;
  logic [31:0]   pc_o;
  logic [FW-1:0] slot_mask_o;
  logic          exc_valid_i = 1'b0;
  logic [31:0]   exc_pc_i = '0;
  logic          branch_taken_i = 1'b0;
  logic [31:0]   pcbranch_i = '0;
  logic          jr_i = 1'b0;
  logic [31:0]   pcjr_i = '0;
  logic          jump_i = 1'b0;
  logic [31:0]   pcjump_i = '0;
  logic          ds_fetched_i = 1'b0;
  logic          flush_o;
  logic          wait_ds_o;
`ifdef PC_GEN_STAT_EN
  logic [31:0]   stat_redirect_o;
  logic [31:0]   stat_exc_o;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_wait;
  bit          m_vld;

  always #5 clk = ~clk;

  pc_gen #(.FETCH_WIDTH(FW), .PC_W(32), .RESET_PC(RPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_valid_o     (pc_valid_o),
    .pc_ready_i     (pc_ready_i),
    .pc_o           (pc_o),
    .slot_mask_o    (slot_mask_o),
    .exc_valid_i    (exc_valid_i),
    .exc_pc_i       (exc_pc_i),
    .branch_taken_i (branch_taken_i),
    .pcbranch_i     (pcbranch_i),
    .jr_i           (jr_i),
    .pcjr_i         (pcjr_i),
    .jump_i         (jump_i),
    .pcjump_i       (pcjump_i),
    .ds_fetched_i   (ds_fetched_i),
    .flush_o        (flush_o),
    .wait_ds_o      (wait_ds_o)
`ifdef PC_GEN_STAT_EN
    ,
    .stat_redirect_o(stat_redirect_o),
    .stat_exc_o     (stat_exc_o)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    n_vec++; if (pc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid_in_reset got %b want 0", pc_valid_o); end
    n_vec++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b want 0", flush_o); end
    reset = 1'b0;
    #1;
    n_vec++; if (pc_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid_first got %b want 0", pc_valid_o); end
    n_vec++; if (pc_o !== RPC) begin n_err++; $display("FAIL reset_pc got %h want %h", pc_o, RPC); end
    n_vec++; if (wait_ds_o !== 1'b0) begin n_err++; $display("FAIL reset_wait got %b want 0", wait_ds_o); end
    n_vec++; if (slot_mask_o !== 2'b11) begin n_err++; $display("FAIL reset_mask got %b want 11", slot_mask_o); end
  endtask

  task automatic test_sequential;
    pc_ready_i = 1'b1;
    tick;
    n_vec++; if (pc_valid_o !== 1'b1) begin n_err++; $display("FAIL seq_valid got %b want 1", pc_valid_o); end
    n_vec++; if (pc_o !== 32'hbfc0_0000) begin n_err++; $display("FAIL seq_pc0 got %h want bfc00000", pc_o); end
    tick;
    n_vec++; if (pc_o !== 32'hbfc0_0008) begin n_err++; $display("FAIL seq_pc1 got %h want bfc00008", pc_o); end
    tick;
    n_vec++; if (pc_o !== 32'hbfc0_0010) begin n_err++; $display("FAIL seq_pc2 got %h want bfc00010", pc_o); end
    n_vec++; if (slot_mask_o !== 2'b11) begin n_err++; $display("FAIL seq_mask got %b want 11", slot_mask_o); end
    pc_ready_i = 1'b0;
  endtask

  task automatic test_delay_slot;
    jump_i = 1'b1; pcjump_i = 32'h8000_1000; ds_fetched_i = 1'b0;
    #1;
    n_vec++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL ds_noflush got %b want 0", flush_o); end
    tick;
    jump_i = 1'b0;
    #1;
    n_vec++; if (wait_ds_o !== 1'b1) begin n_err++; $display("FAIL ds_wait got %b want 1", wait_ds_o); end
    n_vec++; if (pc_o !== 32'hbfc0_0010) begin n_err++; $display("FAIL ds_pc_hold got %h want bfc00010", pc_o); end
    n_vec++; if (slot_mask_o !== 2'b01) begin n_err++; $display("FAIL ds_mask got %b want 01", slot_mask_o); end
    tick;
    n_vec++; if (pc_o !== 32'hbfc0_0010) begin n_err++; $display("FAIL ds_pc_stall got %h want bfc00010", pc_o); end
    pc_ready_i = 1'b1;
    #1;
    n_vec++; if (slot_mask_o !== 2'b01) begin n_err++; $display("FAIL ds_fire_mask got %b want 01", slot_mask_o); end
    n_vec++; if (flush_o !== 1'b0) begin n_err++; $display("FAIL ds_fire_flush got %b want 0", flush_o); end
    tick;
    n_vec++; if (pc_o !== 32'h8000_1000) begin n_err++; $display("FAIL ds_target got %h want 80001000", pc_o); end
    n_vec++; if (wait_ds_o !== 1'b0) begin n_err++; $display("FAIL ds_done_wait got %b want 0", wait_ds_o); end
  endtask

  task automatic test_branch;
    branch_taken_i = 1'b1; pcbranch_i = 32'h8000_0104; ds_fetched_i = 1'b1;
    #1;
    n_vec++; if (flush_o !== 1'b1) begin n_err++; $display("FAIL br_flush got %b want 1", flush_o); end
    tick;
    branch_taken_i = 1'b0; ds_fetched_i = 1'b0;
    #1;
    n_vec++; if (pc_o !== 32'h8000_0104) begin n_err++; $display("FAIL br_pc got %h want 80000104", pc_o); end
    n_vec++; if (slot_mask_o !== 2'b10) begin n_err++; $display("FAIL br_mask got %b want 10", slot_mask_o); end
    tick;
    n_vec++; if (pc_o !== 32'h8000_0108) begin n_err++; $display("FAIL br_next got %h want 80000108", pc_o); end
  endtask

  task automatic test_exc_in_wait;
    pc_ready_i = 1'b0; jump_i = 1'b1; pcjump_i = 32'h8000_2000;
    tick;
    jump_i = 1'b0;
    #1;
    n_vec++; if (wait_ds_o !== 1'b1) begin n_err++; $display("FAIL exc_pre_wait got %b want 1", wait_ds_o); end
    exc_valid_i = 1'b1; exc_pc_i = 32'hbfc0_0380; pc_ready_i = 1'b1;
    #1;
    n_vec++; if (flush_o !== 1'b1) begin n_err++; $display("FAIL exc_flush got %b want 1", flush_o); end
    tick;
    exc_valid_i = 1'b0;
    #1;
    n_vec++; if (pc_o !== 32'hbfc0_0380) begin n_err++; $display("FAIL exc_pc got %h want bfc00380", pc_o); end
    n_vec++; if (wait_ds_o !== 1'b0) begin n_err++; $display("FAIL exc_idle got %b want 0", wait_ds_o); end
    tick;
    n_vec++; if (pc_o !== 32'hbfc0_0388) begin n_err++; $display("FAIL exc_tgt_dropped got %h want bfc00388", pc_o); end
    pc_ready_i = 1'b0;
  endtask

  task automatic test_priority;
    branch_taken_i = 1'b1; pcbranch_i = 32'h1000_0000;
    jr_i = 1'b1; pcjr_i = 32'h2000_0000;
    jump_i = 1'b1; pcjump_i = 32'h3000_0000; ds_fetched_i = 1'b1;
    #1;
    n_vec++; if (flush_o !== 1'b1) begin n_err++; $display("FAIL prio_flush got %b want 1", flush_o); end
    tick;
    n_vec++; if (pc_o !== 32'h1000_0000) begin n_err++; $display("FAIL prio_branch got %h want 10000000", pc_o); end
    exc_valid_i = 1'b1; exc_pc_i = 32'h4000_0000;
    tick;
    n_vec++; if (pc_o !== 32'h4000_0000) begin n_err++; $display("FAIL prio_exc got %h want 40000000", pc_o); end
    exc_valid_i = 1'b0; branch_taken_i = 1'b0;
    tick;
    n_vec++; if (pc_o !== 32'h2000_0000) begin n_err++; $display("FAIL prio_jr got %h want 20000000", pc_o); end
    jr_i = 1'b0; jump_i = 1'b0; ds_fetched_i = 1'b0;
  endtask

  task automatic test_wrap_and_reset;
    pc_ready_i = 1'b0; jump_i = 1'b1; pcjump_i = 32'hffff_fff8; ds_fetched_i = 1'b1;
    tick;
    jump_i = 1'b0; ds_fetched_i = 1'b0;
    #1;
    n_vec++; if (pc_o !== 32'hffff_fff8) begin n_err++; $display("FAIL wrap_pre got %h want fffffff8", pc_o); end
    pc_ready_i = 1'b1;
    tick;
    n_vec++; if (pc_o !== 32'h0000_0000) begin n_err++; $display("FAIL wrap_pc got %h want 00000000", pc_o); end
    pc_ready_i = 1'b0; jump_i = 1'b1; pcjump_i = 32'h8000_3000;
    tick;
    jump_i = 1'b0;
    #1;
    n_vec++; if (wait_ds_o !== 1'b1) begin n_err++; $display("FAIL mrst_pre_wait got %b want 1", wait_ds_o); end
    reset = 1'b1;
    #1;
    n_vec++; if (pc_valid_o !== 1'b0) begin n_err++; $display("FAIL mrst_valid got %b want 0", pc_valid_o); end
    tick;
    reset = 1'b0;
    #1;
    n_vec++; if (pc_o !== RPC) begin n_err++; $display("FAIL mrst_pc got %h want %h", pc_o, RPC); end
    n_vec++; if (wait_ds_o !== 1'b0) begin n_err++; $display("FAIL mrst_wait got %b want 0", wait_ds_o); end
    n_vec++; if (pc_valid_o !== 1'b0) begin n_err++; $display("FAIL mrst_valid_first got %b want 0", pc_valid_o); end
    tick;
    n_vec++; if (pc_valid_o !== 1'b1) begin n_err++; $display("FAIL mrst_valid_after got %b want 1", pc_valid_o); end
  endtask

  // Random traffic; the model tracks the fetch address, a pending target and the wait flag
  task automatic test_random;
    int          off;
    int          sel;
    bit          redir;
    bit          fire;
    logic [31:0] tgt;
    logic [FW-1:0] e_mask;
    logic        e_flush;
    m_pc = RPC; m_tgt = '0; m_wait = 1'b0; m_vld = 1'b1;
    for (int n = 0; n < 400; n++) begin
      pc_ready_i  = ($urandom_range(0, 2) != 0);
      exc_valid_i = ($urandom_range(0, 15) == 0);
      exc_pc_i    = $urandom & 32'hffff_fffc;
      sel = (!m_wait && $urandom_range(0, 4) == 0) ? int'($urandom_range(1, 7)) : 0;
      branch_taken_i = sel[0]; jr_i = sel[1]; jump_i = sel[2];
      pcbranch_i = $urandom & 32'hffff_fffc;
      pcjr_i     = $urandom & 32'hffff_fffc;
      pcjump_i   = ($urandom_range(0, 3) == 0) ? 32'hffff_fff8 : ($urandom & 32'hffff_fffc);
      ds_fetched_i = $urandom_range(0, 1) != 0;
      #1;
      redir = branch_taken_i || jr_i || jump_i;
      tgt = branch_taken_i ? pcbranch_i : (jr_i ? pcjr_i : pcjump_i);
      off = int'((m_pc / 4) % FW);
      e_mask = m_wait ? FW'(1 << off) : FW'(((1 << FW) - 1) & ~((1 << off) - 1));
      e_flush = exc_valid_i || (!m_wait && redir && ds_fetched_i);
      n_vec++; if (pc_valid_o !== m_vld) begin n_err++; $display("FAIL rnd_valid[%0d] got %b want %b", n, pc_valid_o, m_vld); end
      n_vec++; if (pc_o !== m_pc) begin n_err++; $display("FAIL rnd_pc[%0d] got %h want %h", n, pc_o, m_pc); end
      n_vec++; if (slot_mask_o !== e_mask) begin n_err++; $display("FAIL rnd_mask[%0d] got %b want %b", n, slot_mask_o, e_mask); end
      n_vec++; if (flush_o !== e_flush) begin n_err++; $display("FAIL rnd_flush[%0d] got %b want %b", n, flush_o, e_flush); end
      n_vec++; if (wait_ds_o !== m_wait) begin n_err++; $display("FAIL rnd_wait[%0d] got %b want %b", n, wait_ds_o, m_wait); end
      fire = m_vld && pc_ready_i;
      if (exc_valid_i) begin
        m_pc = exc_pc_i; m_wait = 1'b0;
      end else if (m_wait) begin
        if (fire) begin m_pc = m_tgt; m_wait = 1'b0; end
      end else if (redir && ds_fetched_i) begin
        m_pc = tgt;
      end else if (redir) begin
        m_tgt = tgt; m_wait = 1'b1;
      end else if (fire) begin
        m_pc = (m_pc / BB) * BB + BB;
      end
      tick;
    end
    pc_ready_i = 1'b0; exc_valid_i = 1'b0;
    branch_taken_i = 1'b0; jr_i = 1'b0; jump_i = 1'b0; ds_fetched_i = 1'b0;
  endtask

  initial begin
    test_reset;
    test_sequential;
    test_delay_slot;
    test_branch;
    test_exc_in_wait;
    test_priority;
    test_wrap_and_reset;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
